// File: rtl/axis_seq_checker.sv
// AXI-Stream sink that checks an incrementing-word stream (word k == k) with LFSR backpressure.
// Reports pass/fail, a saturating error count and a capture of the first mismatching word.
module axis_seq_checker #(
   parameter int          WIDTH     = 32,
   parameter int          CNT_W     = 32,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             start,
   input  logic [CNT_W-1:0] num_words,
   input  logic             throttle_en,
   input  logic [WIDTH-1:0] i_tdata,
   input  logic             i_tlast,
   input  logic             i_tvalid,
   output logic             i_tready,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [15:0]      err_count,
   output logic [CNT_W-1:0] words_checked,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [WIDTH-1:0] first_err_exp,
   output logic [WIDTH-1:0] first_err_act
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   typedef struct packed {
      logic [CNT_W-1:0] idx;
      logic [WIDTH-1:0] exp;
      logic [WIDTH-1:0] act;
   } err_cap_t;

   state_t           state, state_nxt;
   err_cap_t         err_cap;
   logic [15:0]      lfsr;
   logic             lfsr_fb;
   logic [CNT_W-1:0] num_q;
   logic [WIDTH-1:0] expected;
   logic             arm, xfer, is_last, data_bad, last_bad, mism;

   assign arm      = start && (state != S_RUN);
   // tready comes only from registered state so it never waits on tvalid
   assign i_tready = (state == S_RUN) && (!throttle_en || lfsr[0]);
   assign xfer     = i_tvalid && i_tready;
   assign is_last  = (words_checked == num_q - CNT_W'(1));
   assign data_bad = (i_tdata != expected);
   assign last_bad = (i_tlast != is_last);
   assign mism     = xfer && (data_bad || last_bad);
   assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   assign busy          = (state == S_RUN);
   assign done          = (state == S_DONE);
   assign first_err_idx = err_cap.idx;
   assign first_err_exp = err_cap.exp;
   assign first_err_act = err_cap.act;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE: if (start) state_nxt = (num_words == '0) ? S_DONE : S_RUN;
            S_RUN:          if (xfer && is_last) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr          <= LFSR_SEED;
         num_q         <= '0;
         expected      <= '0;
         words_checked <= '0;
         err_count     <= '0;
         error         <= 1'b0;
         err_cap       <= '0;
      end else if (clear) begin
         lfsr          <= LFSR_SEED;
         num_q         <= '0;
         expected      <= '0;
         words_checked <= '0;
         err_count     <= '0;
         error         <= 1'b0;
         err_cap       <= '0;
      end else if (arm) begin
         lfsr          <= LFSR_SEED;
         num_q         <= num_words;
         expected      <= '0;
         words_checked <= '0;
         err_count     <= '0;
         error         <= 1'b0;
         err_cap       <= '0;
      end else if (state == S_RUN) begin
         // LFSR free-runs in RUN so the stall pattern is independent of the source
         lfsr <= {lfsr[14:0], lfsr_fb};
         if (xfer) begin
            expected      <= expected + WIDTH'(1);
            words_checked <= words_checked + CNT_W'(1);
         end
         if (mism) begin
            error <= 1'b1;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (!error) begin
               err_cap.idx <= words_checked;
               err_cap.exp <= expected;
               err_cap.act <= i_tdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_seq_checker.sv
// Randomized scoreboard bench for axis_seq_checker against a word-level reference model.
`timescale 1ns/1ps
module tb_axis_seq_checker;

   localparam int WIDTH = 32;
   localparam int CNT_W = 32;
   localparam int LIM   = 60000;

   logic             clk = 1'b0;
   logic             reset, clear, start, throttle_en;
   logic [CNT_W-1:0] num_words;
   logic [WIDTH-1:0] i_tdata;
   logic             i_tlast, i_tvalid, i_tready, busy, done, error;
   logic [15:0]      err_count;
   logic [CNT_W-1:0] words_checked, first_err_idx;
   logic [WIDTH-1:0] first_err_exp, first_err_act;

   axis_seq_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .reset(reset), .clear(clear), .start(start), .num_words(num_words),
      .throttle_en(throttle_en), .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
      .i_tready(i_tready), .busy(busy), .done(done), .error(error), .err_count(err_count),
      .words_checked(words_checked), .first_err_idx(first_err_idx),
      .first_err_exp(first_err_exp), .first_err_act(first_err_act)
   );

   always #5 clk = ~clk;

   typedef struct {
      int wc;
      int ec;
      bit err;
   } exp_t;

   exp_t             exp_q[$];
   logic [WIDTH-1:0] src_d[$];
   bit               src_l[$];

   int n_chk = 0, n_fail = 0;
   int m_n, m_idx, m_ec;
   bit m_err;
   logic [WIDTH-1:0] m_fi, m_fe, m_fa;
   int cyc, rdy_hi, rdy_lo;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endfunction

   // Reference model: word idx must equal idx and carry tlast only on the final word
   function automatic void model_xfer(logic [WIDTH-1:0] d, bit l);
      exp_t e;
      bit   bad;
      bad = (d != WIDTH'(m_idx)) || (l != (m_idx == m_n - 1));
      if (bad) begin
         if (!m_err) begin
            m_fi = WIDTH'(m_idx);
            m_fe = WIDTH'(m_idx);
            m_fa = d;
         end
         m_err = 1'b1;
         if (m_ec < 65535) m_ec++;
      end
      m_idx++;
      e.wc = m_idx; e.ec = m_ec; e.err = m_err;
      exp_q.push_back(e);
   endfunction

   // Monitor: every accepted word is followed by a status update one edge later
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("xfer_words_checked", 64'(words_checked), 64'(e.wc));
            chk("xfer_err_count", 64'(err_count), 64'(e.ec));
            chk("xfer_error", 64'(error), 64'(e.err));
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic build(input int n);
      src_d.delete(); src_l.delete();
      for (int i = 0; i < n; i++) begin
         src_d.push_back(WIDTH'(i));
         src_l.push_back(i == n - 1);
      end
   endtask

   task automatic do_start(input int n);
      m_n = n; m_idx = 0; m_ec = 0; m_err = 0; m_fi = 0; m_fe = 0; m_fa = 0;
      num_words = CNT_W'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // thr_mode: 0 = no throttle, 1 = throttle, 2 = throttle toggled randomly per cycle
   task automatic drive(input int thr_mode, input int vpct, input int abort_after);
      int k = 0;
      cyc = 0; rdy_hi = 0; rdy_lo = 0;
      throttle_en = (thr_mode == 1);
      while (k < src_d.size() && cyc < LIM) begin
         if (thr_mode == 2) throttle_en = 1'($urandom_range(0, 1));
         i_tvalid = ($urandom_range(0, 99) < vpct);
         i_tdata  = src_d[k];
         i_tlast  = src_l[k];
         #1;
         if (busy) begin
            if (i_tready) rdy_hi++;
            else          rdy_lo++;
         end
         if (i_tvalid && i_tready) begin
            model_xfer(src_d[k], src_l[k]);
            k++;
         end
         cyc++;
         @(negedge clk);
         if (abort_after > 0 && k == abort_after) break;
      end
      i_tvalid = 1'b0;
      if (cyc >= LIM) chk("stream_timeout", 64'(cyc), 64'(0));
   endtask

   task automatic end_check(input string nm);
      chk({nm, "_done"}, 64'(done), 64'(1));
      chk({nm, "_busy"}, 64'(busy), 64'(0));
      chk({nm, "_tready"}, 64'(i_tready), 64'(0));
      chk({nm, "_words"}, 64'(words_checked), 64'(m_n));
      chk({nm, "_error"}, 64'(error), 64'(m_err));
      chk({nm, "_errcnt"}, 64'(err_count), 64'(m_ec));
      chk({nm, "_fidx"}, 64'(first_err_idx), 64'(m_fi));
      chk({nm, "_fexp"}, 64'(first_err_exp), 64'(m_fe));
      chk({nm, "_fact"}, 64'(first_err_act), 64'(m_fa));
   endtask

   task automatic zero_check(input string nm);
      logic [63:0] all;
      all = 64'(busy) | 64'(done) | 64'(error) | 64'(err_count) | 64'(words_checked)
          | 64'(first_err_idx) | 64'(first_err_exp) | 64'(first_err_act) | 64'(i_tready);
      chk(nm, all, 64'(0));
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; start = 1'b0; throttle_en = 1'b0;
      num_words = '0; i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
      repeat (3) @(negedge clk);
      zero_check("reset_state");
      reset = 1'b0;
      @(negedge clk);
      zero_check("idle_after_reset");

      // Continuous 16-word run, no throttle: one word per cycle
      build(16);
      do_start(16);
      chk("start_busy", 64'(busy), 64'(1));
      drive(0, 100, 0);
      chk("burst_cycles", 64'(cyc), 64'(16));
      end_check("burst16");

      // Long throttled run with random source gaps
      build(10000);
      do_start(10000);
      drive(1, 70, 0);
      chk("throttle_stalls_seen", 64'(rdy_lo != 0), 64'(1));
      end_check("long10000");

      // Data mismatch at index 3
      build(8);
      src_d[3] = 99;
      do_start(8);
      drive(1, 80, 0);
      end_check("data_err");
      chk("data_err_idx_abs", 64'(first_err_idx), 64'(3));
      chk("data_err_act_abs", 64'(first_err_act), 64'(99));

      // tlast early on index 5 and missing on 7
      build(8);
      src_l[5] = 1'b1; src_l[7] = 1'b0;
      do_start(8);
      drive(0, 100, 0);
      end_check("last_err");
      chk("last_err_cnt_abs", 64'(err_count), 64'(2));

      // Zero-length run: immediate DONE, nothing accepted
      do_start(0);
      chk("zero_done", 64'(done), 64'(1));
      i_tvalid = 1'b1;
      rdy_hi = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (i_tready) rdy_hi++;
         @(negedge clk);
      end
      i_tvalid = 1'b0;
      chk("zero_tready_hi", 64'(rdy_hi), 64'(0));
      chk("zero_words", 64'(words_checked), 64'(0));

      // Asynchronous reset after 4 transfers, then a clean rerun
      build(16);
      do_start(16);
      drive(0, 100, 4);
      chk("pre_reset_words", 64'(words_checked), 64'(4));
      reset = 1'b1;
      #1;
      zero_check("midrun_reset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      do_start(16);
      drive(1, 90, 0);
      end_check("after_reset");

      // Synchronous clear after 4 transfers, then a clean rerun
      build(16);
      do_start(16);
      drive(0, 100, 4);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      zero_check("midrun_clear");
      do_start(16);
      drive(0, 100, 0);
      end_check("after_clear");

      // Random corruption with throttle toggling mid-run
      build(300);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 99) < 5) src_d[i] = src_d[i] ^ WIDTH'($urandom_range(1, 255));
         if ($urandom_range(0, 99) < 3) src_l[i] = !src_l[i];
      end
      do_start(300);
      drive(2, 60, 0);
      end_check("random_err");

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
